// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter that hands exactly one header per packet to axi_stream_insert_header.
// Define HDR_ARB_WATCHDOG_EN to add a WAIT_DONE watchdog with a one-cycle 'timeout' pulse.
module axi_stream_header_arbiter #(
    parameter int DATA_WD        = 32,
    parameter int DATA_BYTE_WD   = DATA_WD / 8,
    parameter int BYTE_CNT_WD    = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ        = 4,
    parameter int ID_WD          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD:0]            byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            pkt_done,
    output logic [ID_WD-1:0]                grant_id,
    output logic                            busy,
    output logic                            hdr_drop
`ifdef HDR_ARB_WATCHDOG_EN
    ,
    output logic                            timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_stateNext;
    logic [ID_WD-1:0]          r_ptr;
    logic                      w_found;
    logic [ID_WD-1:0]          w_sel;
    logic [DATA_WD-1:0]        w_selData;
    logic [DATA_BYTE_WD-1:0]   w_selKeep;

    function automatic logic [ID_WD-1:0] wrapIdx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= int'(NUM_REQ)) begin
            s = s - int'(NUM_REQ);
        end
        return ID_WD'(s);
    endfunction

    function automatic logic [BYTE_CNT_WD:0] popCount(input logic [DATA_BYTE_WD-1:0] k);
        logic [BYTE_CNT_WD:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + (BYTE_CNT_WD+1)'(k[i]);
        end
        return c;
    endfunction

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[wrapIdx(int'(r_ptr), i)]) begin
                w_found = 1'b1;
                w_sel   = wrapIdx(int'(r_ptr), i);
            end
        end
    end

    assign w_selData = req_data[w_sel*DATA_WD +: DATA_WD];
    assign w_selKeep = req_keep[w_sel*DATA_BYTE_WD +: DATA_BYTE_WD];

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_found) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    assign busy = (r_state != IDLE);

`ifdef HDR_ARB_WATCHDOG_EN
    localparam int WD_CNT_WD = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_CNT_WD-1:0] r_wdCnt;
    logic                 w_wdExpire;

    // Counter is held at zero outside WAIT_DONE so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdCnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= w_wdExpire;
            if (r_state == WAIT_DONE && w_stateNext == WAIT_DONE) begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end else begin
                r_wdCnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
`ifdef HDR_ARB_WATCHDOG_EN
        w_wdExpire  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_found && (w_selKeep != '0)) begin
                    w_stateNext = OFFER;
                end
            end
            OFFER: begin
                if (ready_insert) begin
                    w_stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pkt_done) begin
                    w_stateNext = IDLE;
                end
`ifdef HDR_ARB_WATCHDOG_EN
                else if (r_wdCnt == WD_CNT_WD'(TIMEOUT_CYCLES - 1)) begin
                    w_stateNext = IDLE;
                    w_wdExpire  = 1'b1;
                end
`endif
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A zero-keep header is consumed and dropped but still advances the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_insert    <= 1'b0;
            data_insert     <= '0;
            keep_insert     <= '0;
            byte_insert_cnt <= '0;
            grant_id        <= '0;
            r_ptr           <= '0;
            hdr_drop        <= 1'b0;
        end else begin
            hdr_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        data_insert     <= w_selData;
                        keep_insert     <= w_selKeep;
                        byte_insert_cnt <= popCount(w_selKeep);
                        grant_id        <= w_sel;
                        r_ptr           <= wrapIdx(int'(w_sel), 1);
                        valid_insert    <= (w_selKeep != '0);
                        hdr_drop        <= (w_selKeep == '0);
                    end
                end
                OFFER: begin
                    if (ready_insert) begin
                        valid_insert <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Scoreboard bench for axi_stream_header_arbiter: per-requester header queues feed the DUT,
// expected grants are queued in issue order and popped on each insert handshake or header drop.
module tb_axi_stream_header_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_WD = 32;
    localparam int KEEP_WD = 4;

    typedef struct {
        int                 id;
        logic [DATA_WD-1:0] data;
        logic [KEEP_WD-1:0] keep;
    } hdr_t;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_WD-1:0]   req_data;
    logic [NUM_REQ*KEEP_WD-1:0]   req_keep;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         valid_insert;
    logic [DATA_WD-1:0]           data_insert;
    logic [KEEP_WD-1:0]           keep_insert;
    logic [2:0]                   byte_insert_cnt;
    logic                         ready_insert;
    logic                         pkt_done;
    logic [1:0]                   grant_id;
    logic                         busy;
    logic                         hdr_drop;
`ifdef HDR_ARB_WATCHDOG_EN
    logic                         timeout;
`endif

    hdr_t hdrQ[NUM_REQ][$];
    hdr_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycles = 0;
    int   hsCycle = 0;
    int   doneTimer = 0;
    int   outstanding = 0;
    bit   autoDone = 1'b0;

    axi_stream_header_arbiter #(
        .DATA_WD(DATA_WD),
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_keep(req_keep),
        .req_ready(req_ready),
        .valid_insert(valid_insert),
        .data_insert(data_insert),
        .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt),
        .ready_insert(ready_insert),
        .pkt_done(pkt_done),
        .grant_id(grant_id),
        .busy(busy),
        .hdr_drop(hdr_drop)
`ifdef HDR_ARB_WATCHDOG_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL globalTimeout: observed still running expected finished");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hdrQ[k].size() > 0) begin
                req_valid[k]                  = 1'b1;
                req_data[k*DATA_WD +: DATA_WD] = hdrQ[k][0].data;
                req_keep[k*KEEP_WD +: KEEP_WD] = hdrQ[k][0].keep;
            end else begin
                req_valid[k] = 1'b0;
            end
        end
    endtask

    // Queue a header on requester id; expected grants are pushed in call order.
    task automatic applyStimulus(input int id, input logic [DATA_WD-1:0] data, input logic [KEEP_WD-1:0] keep);
        hdr_t h;
        h.id   = id;
        h.data = data;
        h.keep = keep;
        hdrQ[id].push_back(h);
        expQ.push_back(h);
        driveInputs();
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstReqReady", 64'(req_ready), 64'd0);
        checkOutput("rstValid", 64'(valid_insert), 64'd0);
        checkOutput("rstData", 64'(data_insert), 64'd0);
        checkOutput("rstKeep", 64'(keep_insert), 64'd0);
        checkOutput("rstCnt", 64'(byte_insert_cnt), 64'd0);
        checkOutput("rstGrant", 64'(grant_id), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDrop", 64'(hdr_drop), 64'd0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hdrQ[k].delete();
        end
        expQ.delete();
        doneTimer    = 0;
        outstanding  = 0;
        autoDone     = 1'b0;
        pkt_done     = 1'b0;
        ready_insert = 1'b0;
        driveInputs();
        #1;
        checkResetOutputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: observe at negedge, let the edge happen, then update requesters and pkt_done.
    task automatic tick();
        logic [NUM_REQ-1:0] rdy;
        hdr_t               e;
        @(negedge clk);
        rdy = req_ready;
        if (rdy != '0) begin
            checkOutput("rdyOneHot", 64'($onehot(rdy)), 64'd1);
            checkOutput("rdyNoPending", 64'(outstanding), 64'd0);
            checkOutput("rdyNotOffering", 64'(valid_insert), 64'd0);
        end
        if (valid_insert && ready_insert) begin
            checkOutput("hsQueued", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("hsId", 64'(grant_id), 64'(e.id));
                checkOutput("hsData", 64'(data_insert), 64'(e.data));
                checkOutput("hsKeep", 64'(keep_insert), 64'(e.keep));
                checkOutput("hsCnt", 64'(byte_insert_cnt), 64'($countones(e.keep)));
            end
            outstanding++;
            hsCycle = cycles;
            if (autoDone) begin
                doneTimer = 5;
            end
        end
        if (hdr_drop) begin
            checkOutput("dropQueued", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("dropId", 64'(grant_id), 64'(e.id));
                checkOutput("dropExpKeep", 64'(keep_insert), 64'(e.keep));
                checkOutput("dropValid", 64'(valid_insert), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        pkt_done = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rdy[k] && hdrQ[k].size() > 0) begin
                void'(hdrQ[k].pop_front());
            end
        end
        driveInputs();
        if (doneTimer > 0) begin
            doneTimer--;
            if (doneTimer == 0) begin
                pkt_done = 1'b1;
                outstanding--;
            end
        end
        cycles++;
    endtask

    task automatic drain(input int maxTicks);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxTicks) begin
            tick();
            n++;
        end
        checkOutput("drainQueue", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        req_valid    = '0;
        req_data     = '0;
        req_keep     = '0;
        ready_insert = 1'b0;
        pkt_done     = 1'b0;
        $display("[TB] start");

        // Single requester: grant, capture and a 10-cycle stall in OFFER.
        resetDut();
        applyStimulus(2, 32'hAABBCCDD, 4'b0111);
        #1;
        checkOutput("t1ReadyComb", 64'(req_ready), 64'h4);
        tick();
        checkOutput("t1Valid", 64'(valid_insert), 64'd1);
        checkOutput("t1Data", 64'(data_insert), 64'hAABBCCDD);
        checkOutput("t1Cnt", 64'(byte_insert_cnt), 64'd3);
        checkOutput("t1Grant", 64'(grant_id), 64'd2);
        checkOutput("t1Busy", 64'(busy), 64'd1);
        checkOutput("t1ReadyAfter", 64'(req_ready), 64'd0);
        applyStimulus(0, 32'h11223344, 4'b1111);
        #1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("holdValid", 64'(valid_insert), 64'd1);
            checkOutput("holdData", 64'(data_insert), 64'hAABBCCDD);
            checkOutput("holdKeep", 64'(keep_insert), 64'h7);
            checkOutput("holdReqReady", 64'(req_ready), 64'd0);
        end
        ready_insert = 1'b1;
        autoDone     = 1'b1;
        drain(100);

        // All requesters busy: rotation 0,1,2,3,0.
        resetDut();
        ready_insert = 1'b1;
        autoDone     = 1'b1;
        applyStimulus(0, 32'hA0A0A0A0, 4'b1111);
        applyStimulus(1, 32'hB1B1B1B1, 4'b0001);
        applyStimulus(2, 32'hC2C2C2C2, 4'b0011);
        applyStimulus(3, 32'hD3D3D3D3, 4'b0111);
        applyStimulus(0, 32'hE0E0E0E0, 4'b0011);
        drain(200);

        // Zero-keep header on requester 1 is dropped, requester 2 follows.
        resetDut();
        ready_insert = 1'b1;
        autoDone     = 1'b1;
        applyStimulus(1, 32'hDEAD0001, 4'b0000);
        applyStimulus(2, 32'h0BADF00D, 4'b0011);
        #1;
        checkOutput("dropReadyFirst", 64'(req_ready), 64'h2);
        tick();
        checkOutput("dropPulse", 64'(hdr_drop), 64'd1);
        checkOutput("dropNoValid", 64'(valid_insert), 64'd0);
        checkOutput("dropNotBusy", 64'(busy), 64'd0);
        checkOutput("dropNextReady", 64'(req_ready), 64'h4);
        drain(100);

        // Asynchronous reset while waiting for end of packet.
        resetDut();
        ready_insert = 1'b1;
        applyStimulus(3, 32'h33333333, 4'b1000);
        drain(20);
        tick();
        tick();
        checkOutput("waitBusy", 64'(busy), 64'd1);
        checkOutput("waitValid", 64'(valid_insert), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        resetDut();
        ready_insert = 1'b1;
        autoDone     = 1'b1;
        applyStimulus(0, 32'h00C0FFEE, 4'b0011);
        applyStimulus(3, 32'h3C3C3C3C, 4'b1111);
        #1;
        checkOutput("rstPrio", 64'(req_ready), 64'h1);
        drain(100);

`ifdef HDR_ARB_WATCHDOG_EN
        // No pkt_done: watchdog releases WAIT_DONE after 16 cycles.
        begin
            int n;
            resetDut();
            ready_insert = 1'b1;
            applyStimulus(0, 32'h57A11ED0, 4'b1111);
            applyStimulus(1, 32'h57A11ED1, 4'b0001);
            n = 0;
            while (outstanding == 0 && n < 20) begin
                tick();
                n++;
            end
            n = 0;
            while (timeout !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            checkOutput("wdTimeout", 64'(timeout), 64'd1);
            checkOutput("wdCycles", 64'(cycles - hsCycle - 1), 64'd16);
            checkOutput("wdBusy", 64'(busy), 64'd0);
            outstanding--;
            drain(20);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_header_arbiter.md
Name: axi_stream_header_arbiter

Overview:
- Round-robin scheduler that shares the header-insert channel of axi_stream_insert_header between NUM_REQ independent header sources.
- Grants exactly one header per packet.
- Presents the header on the insert AXI-Stream port and holds off the next grant until the inserter reports end of packet (last_out handshake).
- Sits directly in front of the inserter's valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert port.

Parameters:
- DATA_WD, 32, header word width in bits
- DATA_BYTE_WD, DATA_WD/8, bytes per word
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte count minus 1
- NUM_REQ, 4, number of header requesters (2..16)
- ID_WD, $clog2(NUM_REQ), grant index width
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester header valid
- req_data  in  NUM_REQ*DATA_WD  packed headers; requester k at [k*DATA_WD +: DATA_WD]
- req_keep  in  NUM_REQ*DATA_BYTE_WD  packed keeps; right-aligned contiguous ones
- req_ready  out  NUM_REQ  one-hot header accept pulse
- valid_insert  out  1  header valid to inserter
- data_insert  out  DATA_WD  header word
- keep_insert  out  DATA_BYTE_WD  header keep
- byte_insert_cnt  out  BYTE_CNT_WD+1  popcount of keep_insert
- ready_insert  in  1  inserter accepts header
- pkt_done  in  1  inserter's valid_out&&ready_out&&last_out
- grant_id  out  ID_WD  index of current/last granted requester
- busy  out  1  high in OFFER and WAIT_DONE
- hdr_drop  out  1  one-cycle pulse when a zero-keep header is discarded

Behaviour:
- Reset values: req_ready=0, valid_insert=0, data_insert=0, keep_insert=0, byte_insert_cnt=0, grant_id=0, busy=0, hdr_drop=0. FSM=IDLE. RR pointer=0, so requester 0 has highest priority first.
- FSM states are IDLE, OFFER and WAIT_DONE.
- IDLE, selection:
  - Selection is combinational over req_valid, scanning from pointer upward with wrap-around.
  - If a winner g exists, req_ready[g]=1 in that same cycle (combinational from state and req_valid; no other bit set).
  - On that clock edge, req_data/req_keep of g are registered into data_insert/keep_insert, and byte_insert_cnt=popcount(req_keep g).
  - On the same edge, grant_id<=g and pointer<=(g+1) mod NUM_REQ.
- IDLE, next state:
  - If the captured keep≠0: valid_insert<=1 and go to OFFER. Latency from req_valid to valid_insert is 1 cycle.
  - If the captured keep==0: header is consumed, hdr_drop pulses, valid_insert stays 0 and the FSM stays in IDLE. The pointer still advances.
- OFFER: valid_insert and all header outputs are held stable until ready_insert=1. On handshake: valid_insert<=0, go to WAIT_DONE.
- WAIT_DONE: on pkt_done=1, go to IDLE. The next grant is earliest on the following cycle, so there is at least one IDLE cycle between packets.
- pkt_done outside WAIT_DONE is ignored, including pkt_done in the same cycle as the OFFER handshake.
- req_valid deasserting while not granted has no effect. Headers from ungranted requesters wait and are never reordered within a requester.
- All requesters continuously valid: grants rotate 0,1,2,3,0,...
- Asynchronous reset in any state returns all state, pointer and outputs to reset values immediately. A header held in OFFER is lost.
- byte_insert_cnt range is 0..DATA_BYTE_WD, with width BYTE_CNT_WD+1.

Optional Feature:
- Macro HDR_ARB_WATCHDOG_EN.
- When defined:
  - Add output timeout (1 bit, reset 0).
  - A cycle counter runs in WAIT_DONE and clears on state entry.
  - If it reaches TIMEOUT_CYCLES without pkt_done: timeout pulses for 1 cycle and the FSM returns to IDLE.
- When undefined: no counter, no timeout port, and WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then req_valid=4'b0100, req_keep2=4'b0111, data 0xAABBCCDD -> req_ready=4'b0100 for 1 cycle; next cycle valid_insert=1, data_insert=0xAABBCCDD, byte_insert_cnt=3, grant_id=2.
- All four requesters valid, ready_insert=1, pkt_done pulsed 5 cycles after each handshake -> grant order 0,1,2,3,0; never two grants without an intervening pkt_done.
- ready_insert=0 for 10 cycles in OFFER -> valid_insert, data_insert and keep_insert unchanged all 10 cycles; req_ready stays 0.
- Requester 1 keep=4'b0000 -> hdr_drop pulses, valid_insert stays 0, and requester 2 (if valid) is granted on the next cycle.
- rst_n asserted while in WAIT_DONE -> all outputs 0 asynchronously; after release, requester 0 wins first over requester 3.
- With HDR_ARB_WATCHDOG_EN defined and TIMEOUT_CYCLES=16, no pkt_done after handshake -> timeout pulses at cycle 16 of WAIT_DONE, busy drops, and the next header is granted.
